// File: rtl/encoder_arbiter.sv
// -----------------------------------------------------------------------------
// encoder_arbiter
//
// Shares one decimal-to-binary encoder between NUM_REQ requesters. Each
// requester offers a 10-bit one-hot decimal digit and raises a request. The
// block picks one requester round-robin, grants it for one cycle, latches the
// offered code, encodes it to 4-bit binary and returns the result tagged with
// the requester id. Codes that are not exactly one-hot are flagged as errors.
//
// One transaction runs IDLE -> LOAD -> ENC -> RESP -> IDLE, so continuous
// requests are served once every 4 cycles.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   req       in   [NUM_REQ]     per-requester request level
//   dec_in    in   [NUM_REQ*10]  one-hot codes, requester i at [i*10 +: 10]
//   gnt       out  [NUM_REQ]     one-hot grant, one cycle per transaction
//   busy      out                high whenever the FSM is not idle
//   out_valid out                one-cycle result strobe
//   out_id    out  [ID_W]        requester owning the result
//   out_bin   out  [4]           encoded binary digit
//   out_err   out                code was not exactly one-hot
//
// ID_W must equal clog2(NUM_REQ); NUM_REQ is supported from 2 to 8.
// -----------------------------------------------------------------------------
module encoder_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*10-1:0]   dec_in,
  output logic [NUM_REQ-1:0]      gnt,
  output logic                    busy,
  output logic                    out_valid,
  output logic [ID_W-1:0]         out_id,
  output logic [3:0]              out_bin,
  output logic                    out_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_ENC  = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] sel_id_q, sel_id_d;
  logic [9:0]      hold_q, hold_d;
  logic [ID_W-1:0] out_id_q, out_id_d;
  logic [3:0]      out_bin_q, out_bin_d;
  logic            out_err_q, out_err_d;

  // Round-robin pick: first set request at or above ptr, wrapping.
  // Scanning offsets from highest to lowest lets the smallest offset win.
  logic [ID_W-1:0] rr_pick;
  logic            rr_any;

  always_comb begin
    int idx;
    idx     = 0;
    rr_pick = '0;
    rr_any  = 1'b0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      idx = int'(ptr_q) + off;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (req[idx]) begin
        rr_pick = ID_W'(idx);
        rr_any  = 1'b1;
      end
    end
  end

  // Decimal encoder on the held code: count set bits and remember the
  // position of the last one; only a count of exactly one is a valid digit.
  logic [3:0] enc_cnt;
  logic [3:0] enc_idx;
  logic       enc_onehot;

  always_comb begin
    enc_cnt = 4'd0;
    enc_idx = 4'd0;
    for (int k = 0; k < 10; k++) begin
      if (hold_q[k]) begin
        enc_cnt = enc_cnt + 4'd1;
        enc_idx = 4'(k);
      end
    end
    enc_onehot = (enc_cnt == 4'd1);
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_id_d  = sel_id_q;
    hold_d    = hold_q;
    out_id_d  = out_id_q;
    out_bin_d = out_bin_q;
    out_err_d = out_err_q;
    case (state_q)
      S_IDLE: begin
        if (rr_any) begin
          sel_id_d = rr_pick;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        hold_d  = dec_in[int'(sel_id_q)*10 +: 10];
        state_d = S_ENC;
      end
      S_ENC: begin
        out_bin_d = enc_onehot ? enc_idx : 4'd0;
        out_err_d = ~enc_onehot;
        out_id_d  = sel_id_q;
        state_d   = S_RESP;
      end
      S_RESP: begin
        // The requester just served drops to lowest priority.
        ptr_d   = (sel_id_q == ID_W'(NUM_REQ - 1)) ? '0 : sel_id_q + ID_W'(1);
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      sel_id_q  <= '0;
      hold_q    <= '0;
      out_id_q  <= '0;
      out_bin_q <= '0;
      out_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_id_q  <= sel_id_d;
      hold_q    <= hold_d;
      out_id_q  <= out_id_d;
      out_bin_q <= out_bin_d;
      out_err_q <= out_err_d;
    end
  end

  // Grant is decoded straight from state so an async reset drops it at once.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_gnt
    assign gnt[gi] = (state_q == S_LOAD) && (sel_id_q == ID_W'(gi));
  end

  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_RESP);
  assign out_id    = out_id_q;
  assign out_bin   = out_bin_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_encoder_arbiter.sv
module tb_encoder_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*10-1:0] dec_in;
  logic [NUM_REQ-1:0]    gnt;
  logic                  busy;
  logic                  out_valid;
  logic [ID_W-1:0]       out_id;
  logic [3:0]            out_bin;
  logic                  out_err;

  int total = 0;
  int bad   = 0;

  encoder_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .dec_in    (dec_in),
    .gnt       (gnt),
    .busy      (busy),
    .out_valid (out_valid),
    .out_id    (out_id),
    .out_bin   (out_bin),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  // One-hot code for digit d.
  function automatic logic [9:0] digit(input int d);
    logic [9:0] v;
    v = '0;
    v[d] = 1'b1;
    return v;
  endfunction

  task automatic set_slice(input int i, input logic [9:0] code);
    dec_in[i*10 +: 10] = code;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Runs one full transaction starting in IDLE with req/dec_in already set,
  // checking grant, latency and the tagged result. Returns 1ns after the
  // RESP->IDLE edge so the next call can continue back to back.
  task automatic run_txn(input string name, input int id, input logic [3:0] bin,
                         input logic err, input logic drop_req);
    logic [NUM_REQ-1:0] exp_gnt;
    exp_gnt = '0;
    exp_gnt[id] = 1'b1;
    @(posedge clk); #1;
    total++;
    if (gnt !== exp_gnt || busy !== 1'b1) begin
      bad++;
      $display("FAIL %s grant: gnt=%b busy=%b required gnt=%b busy=1", name, gnt, busy, exp_gnt);
    end
    if (drop_req) req = '0;
    @(posedge clk); #1;
    total++;
    if (gnt !== '0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s enc: gnt=%b out_valid=%b required gnt=0000 out_valid=0", name, gnt, out_valid);
    end
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b1 || out_id !== ID_W'(id) || out_bin !== bin || out_err !== err) begin
      bad++;
      $display("FAIL %s result: valid=%b id=%0d bin=%0d err=%b required valid=1 id=%0d bin=%0d err=%b",
               name, out_valid, out_id, out_bin, out_err, id, bin, err);
    end
    $display("txn %s: id=%0d bin=%0d err=%b (required id=%0d bin=%0d err=%b)",
             name, out_id, out_bin, out_err, id, bin, err);
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s done: out_valid=%b busy=%b required 0 0", name, out_valid, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    dec_in = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (gnt !== '0 || busy !== 1'b0 || out_valid !== 1'b0 || out_id !== '0 ||
        out_bin !== 4'd0 || out_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: gnt=%b busy=%b valid=%b id=%0d bin=%0d err=%b required all 0",
               gnt, busy, out_valid, out_id, out_bin, out_err);
    end
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      total++;
      if (gnt !== '0 || busy !== 1'b0 || out_valid !== 1'b0 || out_bin !== 4'd0) begin
        bad++;
        $display("FAIL idle_cycle%0d: gnt=%b busy=%b valid=%b bin=%0d required 0 0 0 0",
                 c, gnt, busy, out_valid, out_bin);
      end
    end
  endtask

  task automatic test_single();
    set_slice(2, 10'b00_1000_0000);
    req = 4'b0100;
    run_txn("single_id2", 2, 4'd7, 1'b0, 1'b1);
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || out_id !== 2'd2 || out_bin !== 4'd7 || out_err !== 1'b0) begin
      bad++;
      $display("FAIL result_hold: valid=%b id=%0d bin=%0d err=%b required 0 2 7 0",
               out_valid, out_id, out_bin, out_err);
    end
  endtask

  // ptr is 3 here, so id 3 wins before wrapping to id 0.
  task automatic test_wrap();
    set_slice(0, digit(4));
    set_slice(3, digit(9));
    req = 4'b1001;
    run_txn("wrap_id3", 3, 4'd9, 1'b0, 1'b0);
    run_txn("wrap_id0", 0, 4'd4, 1'b0, 1'b1);
  endtask

  task automatic test_errors();
    set_slice(1, 10'b00_0001_0010);
    req = 4'b0010;
    run_txn("err_two_bits", 1, 4'd0, 1'b1, 1'b1);
    set_slice(3, 10'b0);
    req = 4'b1000;
    run_txn("err_zero", 3, 4'd0, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_slice(0, digit(0));
    set_slice(1, digit(3));
    set_slice(2, digit(5));
    set_slice(3, digit(9));
    req = 4'b1111;
    run_txn("rr_0", 0, 4'd0, 1'b0, 1'b0);
    run_txn("rr_1", 1, 4'd3, 1'b0, 1'b0);
    run_txn("rr_2", 2, 4'd5, 1'b0, 1'b0);
    run_txn("rr_3", 3, 4'd9, 1'b0, 1'b0);
    run_txn("rr_4", 0, 4'd0, 1'b0, 1'b1);
  endtask

  task automatic test_mid_reset();
    do_reset();
    // Reset while the grant is up: grant must vanish without a clock edge.
    set_slice(1, digit(1));
    req = 4'b0010;
    @(posedge clk); #1;
    total++;
    if (gnt !== 4'b0010) begin
      bad++;
      $display("FAIL load_gnt: gnt=%b required 0010", gnt);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (gnt !== '0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL load_abort: gnt=%b busy=%b required 0000 0", gnt, busy);
    end
    req = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL load_abort_novalid%0d: out_valid=%b required 0", c, out_valid);
      end
    end

    // Serve id 1 so ptr moves to 2, then abort an id 2 transaction in ENC.
    set_slice(1, digit(8));
    req = 4'b0010;
    run_txn("pre_abort_id1", 1, 4'd8, 1'b0, 1'b1);
    set_slice(2, digit(2));
    req = 4'b0100;
    @(posedge clk); #1;
    total++;
    if (gnt !== 4'b0100) begin
      bad++;
      $display("FAIL abort_gnt: gnt=%b required 0100", gnt);
    end
    req = '0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    total++;
    if (gnt !== '0 || busy !== 1'b0 || out_valid !== 1'b0 || out_bin !== 4'd0 || out_id !== '0) begin
      bad++;
      $display("FAIL enc_abort: gnt=%b busy=%b valid=%b bin=%0d id=%0d required 0000 0 0 0 0",
               gnt, busy, out_valid, out_bin, out_id);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL enc_abort_novalid%0d: out_valid=%b required 0", c, out_valid);
      end
    end
    // ptr is back at 0, so id 1 wins over id 3.
    set_slice(1, digit(6));
    set_slice(3, digit(5));
    req = 4'b1010;
    run_txn("post_reset_id1", 1, 4'd6, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    dec_in = '0;
    test_reset();
    test_single();
    test_wrap();
    test_errors();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
